// File: rtl/sponge_pkg.sv
// Shared types and helpers for the sponge block packer: FSM state encoding,
// default pad bytes and the pad-word builder.
package sponge_pkg;

  typedef enum logic [1:0] {
    ABSORB = 2'd0,
    PAD    = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam logic [7:0] DEF_PAD_BEGINNING = 8'h1F;
  localparam logic [7:0] DEF_PAD_ENDING    = 8'h80;
  localparam int         MAX_IN_W          = 1024;

  // Pad word for one slot; the caller keeps the low in_width bits.
  function automatic logic [MAX_IN_W-1:0] pad_word(input int unsigned in_width,
                                                   input logic first,
                                                   input logic is_final,
                                                   input logic [7:0] pad_begin,
                                                   input logic [7:0] pad_end);
    logic [MAX_IN_W-1:0] w;
    logic [9:0]          top;
    w   = '0;
    top = 10'(in_width - 8);
    if (first) w[7:0] = pad_begin;
    if (is_final) w[top +: 8] = w[top +: 8] | pad_end;
    return w;
  endfunction

endpackage

// File: rtl/block_out_reg.sv
// One-entry output register for rate blocks. A block is transferred when
// out_valid && out_ready; load is only raised by the packer when can_load=1.
module block_out_reg #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         load,
  input  logic [W-1:0] load_block,
  input  logic         load_last,
  input  logic         out_ready,
  output logic [W-1:0] out_block,
  output logic         out_valid,
  output logic         out_last,
  output logic         can_load
);

  // Free when empty or being emptied this cycle, so load and transfer can overlap.
  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      out_block <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_block <= load_block;
      out_last  <= load_last;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/sponge_block_packer.sv
// Packs IN_WIDTH-bit words into OUT_WIDTH-bit sponge rate blocks with a
// double-buffered output. Define SPONGE_PAD_EN to enable multi-rate padding.
module sponge_block_packer
  import sponge_pkg::*;
#(
  parameter int         IN_WIDTH      = 8,
  parameter int         OUT_WIDTH     = 256,
  parameter int         WORDS         = OUT_WIDTH / IN_WIDTH,
  parameter int         CNT_W         = $clog2(WORDS),
  parameter logic [7:0] PAD_BEGINNING = DEF_PAD_BEGINNING,
  parameter logic [7:0] PAD_ENDING    = DEF_PAD_ENDING
) (
  input  logic                 clk,
  input  logic                 clear_n,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_block,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 start_squeeze,
  output logic [1:0]           dbg_state
);

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WORDS - 1);

  state_t               state, state_next;
  logic [OUT_WIDTH-1:0] pack, pack_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic                 full, full_next;
  logic                 last_flag, last_next;
  logic                 can_load, move, in_fire, at_end;
  logic                 write, zero_tail;
  logic [IN_WIDTH-1:0]  word;
`ifdef SPONGE_PAD_EN
  logic                 pad_first, pad_first_next;
  logic [MAX_IN_W-1:0]  pw;
`endif

  assign move      = full && can_load;
  assign at_end    = (cnt == LAST_SLOT);
  assign in_ready  = (state == ABSORB) && (!full || can_load);
  assign in_fire   = in_valid && in_ready;
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    full_next  = full && !move;
    last_next  = last_flag && !move;
    write      = 1'b0;
    zero_tail  = 1'b0;
    word       = '0;
`ifdef SPONGE_PAD_EN
    pad_first_next = pad_first;
    pw             = '0;
`endif
    case (state)
      ABSORB: begin
        if (in_fire) begin
          write    = 1'b1;
          word     = in_data;
          cnt_next = at_end ? '0 : cnt + 1'b1;
          if (at_end) full_next = 1'b1;
          if (in_last) begin
`ifdef SPONGE_PAD_EN
            state_next     = PAD;
            pad_first_next = 1'b1;
`else
            // Zero the unused tail in the same cycle; the block is final as-is.
            zero_tail  = 1'b1;
            full_next  = 1'b1;
            last_next  = 1'b1;
            cnt_next   = '0;
            state_next = DRAIN;
`endif
          end
        end
      end
`ifdef SPONGE_PAD_EN
      PAD: begin
        if (!full || can_load) begin
          pw             = pad_word(IN_WIDTH, pad_first, at_end, PAD_BEGINNING, PAD_ENDING);
          write          = 1'b1;
          word           = pw[IN_WIDTH-1:0];
          pad_first_next = 1'b0;
          cnt_next       = at_end ? '0 : cnt + 1'b1;
          if (at_end) begin
            full_next  = 1'b1;
            last_next  = 1'b1;
            state_next = DRAIN;
          end
        end
      end
`endif
      DRAIN: begin
        if (!full && out_valid && out_ready && out_last) begin
          state_next = ABSORB;
          cnt_next   = '0;
        end
      end
      default: state_next = ABSORB;
    endcase

    pack_next = pack;
    for (int k = 0; k < WORDS; k++) begin
      if (write && (CNT_W'(k) == cnt))
        pack_next[k*IN_WIDTH +: IN_WIDTH] = word;
      else if (zero_tail && (CNT_W'(k) > cnt))
        pack_next[k*IN_WIDTH +: IN_WIDTH] = '0;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state         <= ABSORB;
      pack          <= '0;
      cnt           <= '0;
      full          <= 1'b0;
      last_flag     <= 1'b0;
      start_squeeze <= 1'b0;
`ifdef SPONGE_PAD_EN
      pad_first     <= 1'b0;
`endif
    end else begin
      state         <= state_next;
      pack          <= pack_next;
      cnt           <= cnt_next;
      full          <= full_next;
      last_flag     <= last_next;
      start_squeeze <= out_valid && out_ready && out_last;
`ifdef SPONGE_PAD_EN
      pad_first     <= pad_first_next;
`endif
    end
  end

  block_out_reg #(.W(OUT_WIDTH)) u_out (
    .clk       (clk),
    .clear_n   (clear_n),
    .load      (move),
    .load_block(pack),
    .load_last (last_flag),
    .out_ready (out_ready),
    .out_block (out_block),
    .out_valid (out_valid),
    .out_last  (out_last),
    .can_load  (can_load)
  );

endmodule

// File: tb/tb_sponge_block_packer.sv
// Directed bench for sponge_block_packer (IN_WIDTH=8, OUT_WIDTH=256); expected
// blocks follow SPONGE_PAD_EN when it is defined for the build.
module tb_sponge_block_packer;

`ifdef SPONGE_PAD_EN
  localparam bit PAD_MODE = 1'b1;
`else
  localparam bit PAD_MODE = 1'b0;
`endif

  logic         clk;
  logic         clear_n;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [255:0] out_block;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;
  logic         start_squeeze;
  logic [1:0]   dbg_state;

  sponge_block_packer dut (
    .clk          (clk),
    .clear_n      (clear_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_block    (out_block),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .start_squeeze(start_squeeze),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic [255:0] exp_q[$];
  bit           exp_last_q[$];
  int           blocks_rcvd;
  int           sq_cnt;
  int           stall_seen;
  logic [255:0] last_blk;
  logic         hold_pending;
  logic [255:0] hold_blk;
  logic         hold_last;
  logic         prev_last_fire;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: sampled on the falling edge, a handshake seen here completes at the next rising edge
  always @(negedge clk) begin
    if (!clear_n) begin
      hold_pending   = 1'b0;
      prev_last_fire = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_block", out_block, hold_blk);
        check("hold_last", out_last, hold_last);
      end
      check("squeeze_pulse", start_squeeze, prev_last_fire);
      if (start_squeeze) sq_cnt++;
      if (in_valid && !in_ready) stall_seen++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_block", out_block, '0);
        end else begin
          check("block_data", out_block, exp_q.pop_front());
          check("block_last", out_last, exp_last_q.pop_front());
        end
        last_blk = out_block;
        blocks_rcvd++;
      end
      hold_pending   = out_valid && !out_ready;
      hold_blk       = out_block;
      hold_last      = out_last;
      prev_last_fire = out_valid && out_ready && out_last;
    end
  end

  // reference model: message bytes base, base+1, ... then padding, cut into 32-byte blocks
  task automatic push_expect(input int len, input int base);
    logic [7:0]   bytes[$];
    logic [255:0] blk;
    int           r;
    int           nblk;
    for (int i = 0; i < len; i++) bytes.push_back(8'(base + i));
    if (PAD_MODE) begin
      r = 32 - (len % 32);
      for (int i = 0; i < r; i++) bytes.push_back(8'h00);
      bytes[len]       = bytes[len] | 8'h1F;
      bytes[len+r-1]   = bytes[len+r-1] | 8'h80;
    end else begin
      while (bytes.size() % 32 != 0) bytes.push_back(8'h00);
    end
    nblk = bytes.size() / 32;
    for (int b = 0; b < nblk; b++) begin
      blk = '0;
      for (int j = 0; j < 32; j++) blk[j*8 +: 8] = bytes[b*32 + j];
      exp_q.push_back(blk);
      exp_last_q.push_back(b == nblk - 1);
    end
  endtask

  // driver: called and returns at posedge+1
  task automatic send_msg(input int len, input int base, input bit do_last, input bit gaps);
    int t;
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_last  = 1'b1;
        in_data  = 8'hEE;
        @(posedge clk); #1;
      end
      in_data  = 8'(base + i);
      in_valid = 1'b1;
      in_last  = do_last && (i == len - 1);
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 1000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 1000) ok = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("in_accept_timeout", ok, 1'b1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || sq_cnt == 0) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("done_timeout", t < 3000, 1'b1);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic run_msg(input int len, input int base, input bit gaps);
    blocks_rcvd = 0;
    sq_cnt      = 0;
    push_expect(len, base);
    send_msg(len, base, 1'b1, gaps);
    wait_done();
  endtask

  initial begin
    int t;
    clear_n      = 1'b0;
    in_data      = '0;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    out_ready    = 1'b1;
    sq_cnt       = 0;
    blocks_rcvd  = 0;
    stall_seen   = 0;
    last_blk     = '0;
    hold_pending = 1'b0;
    prev_last_fire = 1'b0;

    // reset state
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_block", out_block, '0);
    check("rst_squeeze", start_squeeze, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    @(posedge clk); #1;
    clear_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1'b1);

    // 3-byte message 01 02 03
    run_msg(3, 8'h01, 1'b0);
    check("m3_blocks", blocks_rcvd, 1);
    check("m3_squeeze", sq_cnt, 1);
    check("m3_byte0", last_blk[7:0], 8'h01);
    check("m3_byte2", last_blk[23:16], 8'h03);
    check("m3_byte3", last_blk[31:24], PAD_MODE ? 8'h1F : 8'h00);
    check("m3_byte31", last_blk[255:248], PAD_MODE ? 8'h80 : 8'h00);
    check("m3_state", dbg_state, 2'd0);

    // 31-byte message: final slot carries both pad bytes
    run_msg(31, 8'h40, 1'b0);
    check("m31_blocks", blocks_rcvd, 1);
    check("m31_byte30", last_blk[247:240], 8'h5E);
    check("m31_byte31", last_blk[255:248], PAD_MODE ? 8'h9F : 8'h00);

    // 32-byte message: extra pad block only with padding
    run_msg(32, 8'h80, 1'b0);
    check("m32_blocks", blocks_rcvd, PAD_MODE ? 2 : 1);
    check("m32_byte0", last_blk[7:0], PAD_MODE ? 8'h1F : 8'h80);
    check("m32_byte31", last_blk[255:248], PAD_MODE ? 8'h80 : 8'h9F);
    check("m32_squeeze", sq_cnt, 1);

    // gaps with stray in_last while in_valid=0
    run_msg(5, 8'hC0, 1'b1);
    check("gap_blocks", blocks_rcvd, 1);
    check("gap_byte4", last_blk[39:32], 8'hC4);
    check("gap_byte5", last_blk[47:40], PAD_MODE ? 8'h1F : 8'h00);

    // 70-byte message with the consumer stalled 50 cycles after the first block appears
    blocks_rcvd = 0;
    sq_cnt      = 0;
    stall_seen  = 0;
    push_expect(70, 8'h10);
    out_ready = 1'b0;
    fork
      send_msg(70, 8'h10, 1'b1, 1'b0);
      begin
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 500) begin
          @(negedge clk);
          t++;
        end
        check("stall_first_valid", out_valid, 1'b1);
        repeat (50) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_done();
    check("m70_blocks", blocks_rcvd, 3);
    check("m70_in_ready_drop", stall_seen > 0, 1'b1);
    check("m70_byte5", last_blk[47:40], 8'h55);
    check("m70_byte6", last_blk[55:48], PAD_MODE ? 8'h1F : 8'h00);

    // reset mid-block with one block parked in the output register
    out_ready = 1'b0;
    send_msg(40, 8'hA0, 1'b0, 1'b0);
    check("pre_rst_valid", out_valid, 1'b1);
    #2 clear_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_last", out_last, 1'b0);
    check("mid_rst_block", out_block, '0);
    check("mid_rst_squeeze", start_squeeze, 1'b0);
    check("mid_rst_state", dbg_state, 2'd0);
    @(negedge clk);
    @(posedge clk); #1;
    clear_n = 1'b1;
    exp_q.delete();
    exp_last_q.delete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    run_msg(3, 8'h01, 1'b0);
    check("post_rst_blocks", blocks_rcvd, 1);
    check("post_rst_byte0", last_blk[7:0], 8'h01);
    check("post_rst_byte3", last_blk[31:24], PAD_MODE ? 8'h1F : 8'h00);
    check("post_rst_byte8", last_blk[71:64], 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
